// File: rtl/digit_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_store_pkg
//  Purpose  : Shared sizes and types for the keypad digit-entry buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package digit_store_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage : digit_store_pkg
`default_nettype wire

// File: rtl/digit_store_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_detect
//  Purpose  : Single-cycle pulse on a 0->1 transition of a level input.
//             The previous value resets to 0, so an input already high when
//             reset releases is seen as a rising edge on the first clock.
//  Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Remember the input from the previous clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/digit_store.sv
`default_nettype none
// ============================================================================
//  Module   : digit_store
//  Purpose  : Calculator-style entry buffer. Digits shift in from the right
//             on each key press until the buffer is full; later presses are
//             ignored. Clear or reset empties it. The populated mask and
//             full flag are decoded from the stored digit count.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_store #(
    parameter int NUM_DIGITS = digit_store_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = digit_store_pkg::DIGIT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          valid,
    input  logic                          clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0] out,
    output logic [NUM_DIGITS-1:0]         digitsToDisplay,
    output logic                          storageFull
);

    import digit_store_pkg::*;

    localparam int C_OUT_W = NUM_DIGITS * DIGIT_W;
    localparam int C_CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(NUM_DIGITS);

    logic [C_OUT_W-1:0] out_q;
    logic [C_OUT_W-1:0] out_d;
    logic [C_CNT_W-1:0] count_q;
    logic [C_CNT_W-1:0] count_d;
    logic               accept;

    // A held key-press strobe must enter only one digit.
    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .in    (valid),
        .pulse (accept)
    );

    // Next entry: clear has priority, otherwise shift in while not full.
    always_comb begin
        out_d   = out_q;
        count_d = count_q;
        if (clear) begin
            out_d   = '0;
            count_d = '0;
        end else if (accept && (count_q < C_FULL)) begin
            out_d   = (out_q << DIGIT_W) | C_OUT_W'(digit);
            count_d = count_q + C_CNT_W'(1);
        end
    end

    // Digit shift register and populated-slot count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            count_q <= '0;
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

    // Thermometer mask: slot i is populated once more than i digits are held.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_mask
        assign digitsToDisplay[i] = (count_q > C_CNT_W'(i));
    end

    assign storageFull = (count_q == C_FULL);
    assign out         = out_q;

endmodule : digit_store
`default_nettype wire

// File: tb/tb_digit_store.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_store
//  Purpose  : Self-checking bench for digit_store against a queue-based
//             model of the entered key sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digit_store;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    logic                          clk   = 1'b0;
    logic                          reset = 1'b1;
    logic [DIGIT_W-1:0]            digit = '0;
    logic                          valid = 1'b0;
    logic                          clear = 1'b0;
    logic [NUM_DIGITS*DIGIT_W-1:0] out;
    logic [NUM_DIGITS-1:0]         digitsToDisplay;
    logic                          storageFull;

    int n_total = 0;
    int n_bad   = 0;

    // Model: the digits currently held, oldest first, and the last valid level.
    int unsigned m_q[$];
    bit          m_prev = 1'b0;

    digit_store #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .digit           (digit),
        .valid           (valid),
        .clear           (clear),
        .out             (out),
        .digitsToDisplay (digitsToDisplay),
        .storageFull     (storageFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_value();
        logic [31:0] v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".out"},  32'(out), exp_value());
        chk({tag, ".mask"}, 32'(digitsToDisplay), (32'd1 << m_q.size()) - 1);
        chk({tag, ".full"}, 32'(storageFull), 32'(m_q.size() == NUM_DIGITS));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step(input bit v, input int unsigned d, input bit c, input string tag);
        valid = v;
        digit = DIGIT_W'(d);
        clear = c;
        @(posedge clk);
        if (c) m_q.delete();
        else if (v && !m_prev && m_q.size() < NUM_DIGITS) m_q.push_back(d);
        m_prev = v;
        #1;
        check_model(tag);
    endtask

    task automatic press(input int unsigned d, input string tag);
        step(1'b1, d, 1'b0, tag);
        step(1'b0, d, 1'b0, tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, clear of any rising edge.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        m_q.delete();
        m_prev = 1'b0;
        chk({tag, ".rst_out"},  32'(out), 32'h0);
        chk({tag, ".rst_mask"}, 32'(digitsToDisplay), 32'h0);
        chk({tag, ".rst_full"}, 32'(storageFull), 32'h0);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // Reset before any clock edge has occurred.
        #2;
        reset = 1'b0;
        #1;
        chk("por.out",  32'(out), 32'h0);
        chk("por.mask", 32'(digitsToDisplay), 32'h0);
        chk("por.full", 32'(storageFull), 32'h0);
        #3;
        reset = 1'b1;
        step(1'b0, 0, 1'b0, "idle");

        // 0, 9, B, 3 then overflow keys D, 1, F.
        press(4'h0, "d0");
        chk("d0.mask_plan", 32'(digitsToDisplay), 32'h1);
        press(4'h9, "d9");
        chk("d9.plan", 32'(out), 32'h0009);
        press(4'hB, "dB");
        chk("dB.plan", 32'(out), 32'h009B);
        press(4'h3, "d3");
        chk("d3.plan", 32'(out), 32'h09B3);
        chk("d3.full_plan", 32'(storageFull), 32'h1);
        press(4'hD, "ovD");
        press(4'h1, "ov1");
        press(4'hF, "ovF");
        chk("ov.plan", 32'(out), 32'h09B3);

        // Held valid enters a single digit.
        step(1'b0, 0, 1'b1, "clr");
        for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, "hold7");
        step(1'b0, 7, 1'b0, "hold7_end");
        chk("hold7.plan", 32'(out), 32'h0007);

        // Clear wins over a simultaneous rising valid.
        step(1'b0, 0, 1'b1, "clr2");
        press(1, "c1");
        press(2, "c2");
        step(1'b1, 5, 1'b1, "clr_vs_acc");
        chk("clr_vs_acc.plan", 32'(out), 32'h0);
        step(1'b0, 5, 1'b0, "after_clr");
        press(5, "d5");
        chk("d5.plan", 32'(out), 32'h0005);

        // Async reset mid-entry, then a fresh digit.
        step(1'b0, 0, 1'b1, "clr3");
        press(4'hA, "dA");
        press(4'hB, "dB2");
        press(4'hC, "dC");
        async_reset("midentry");
        press(4, "d4");
        chk("d4.plan", 32'(out), 32'h0004);

        // Valid high across reset release counts as a rising edge.
        valid = 1'b1;
        digit = 4'h6;
        async_reset("vhigh");
        step(1'b1, 6, 1'b0, "vhigh_first");
        step(1'b0, 6, 1'b0, "vhigh_low");

        // Randomised presses, holds, clears and occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit          v = ($urandom_range(0, 99) < 45);
            bit          c = ($urandom_range(0, 99) < 5);
            int unsigned d = $urandom_range(0, 15);
            step(v, d, c, "rand");
            if ($urandom_range(0, 99) < 2) async_reset("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_digit_store
`default_nettype wire

// File: doc/digit_store.md
# digit_store

Entry buffer for the security device's keypad path: it collects up to four 4-bit hex digits from the keypad decoder, presents them as a packed 16-bit value for the seven-segment display and code comparator, and reports which display positions are populated and when the buffer is full. Digits shift in from the right, like a calculator display. The buffer is emptied by an explicit clear or by reset.

## Interface
- NUM_DIGITS, default 4: number of digit slots.
- DIGIT_W, default 4: bits per digit.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- digit  input  DIGIT_W  digit value from the keypad decoder; sampled only on an accept cycle.
- valid  input  1  key-press strobe; may be held high for any number of cycles.
- clear  input  1  synchronous clear of the stored entry.
- out  output  NUM_DIGITS*DIGIT_W (16)  stored digits; most recent digit in out[3:0], oldest in the highest populated nibble; unpopulated nibbles read 0.
- digitsToDisplay  output  NUM_DIGITS (4)  populated-slot mask, thermometer coded from bit 0 (count 0=0000, 1=0001, 2=0011, 3=0111, 4=1111).
- storageFull  output  1  high when count == NUM_DIGITS.

## Operation
- State: digit shift register (NUM_DIGITS×DIGIT_W), count (0..NUM_DIGITS, $clog2(NUM_DIGITS+1) bits), valid_q (previous valid).
- Accept condition: valid==1 && valid_q==0 (rising edge of valid). A held valid enters exactly one digit.
- Accept with count<NUM_DIGITS: out <= {out[NUM_DIGITS*DIGIT_W-DIGIT_W-1:0], digit}; count <= count+1.
- Accept with count==NUM_DIGITS: digit discarded; out and count unchanged (first four digits retained).
- clear==1: out <= 0, count <= 0 regardless of valid; a simultaneous accept is discarded. valid_q still updates, so a valid held across clear does not re-enter a digit.
- Digit value 0 is a real digit: it increments count and sets a mask bit even though out is unchanged numerically.
- digitsToDisplay and storageFull are combinational decodes of count; out is the register directly.
- Reset (reset==0, asynchronous, any time including mid-entry): out=0, count=0, valid_q=0, so digitsToDisplay=0000 and storageFull=0. If valid is high when reset releases, it counts as a rising edge on the first clock.

## Timing
- An accept sampled at rising edge N is visible on out, digitsToDisplay and storageFull immediately after edge N (one-edge latency, no extra pipeline).
- A clear sampled at edge N shows empty outputs after edge N.
- Minimum key-press spacing: valid low for at least one cycle between presses; back-to-back high cycles count as one press.
- No combinational path from digit, valid or clear to any output.

## Structure
- Package digit_store_pkg: DIGIT_W, NUM_DIGITS, typedef digit_t (logic [DIGIT_W-1:0]), and count width constant.
- Sub-module rise_detect (clk, reset, in -> pulse): registered previous value, async active-low reset to 0. It is reused by other keypad-path blocks.
- The top level holds the shift register, count, and the combinational mask/full decode.

## Test plan
- Reset then idle: hold reset=0 mid-cycle -> out=0000, digitsToDisplay=0000, storageFull=0 without waiting for a clock edge.
- Enter 0, 9, B, 3 as one-cycle valid pulses separated by one low cycle -> out=0x0009, 0x009B, 0x09B3 after the 2nd, 3rd and 4th digits; mask steps 0001, 0011, 0111, 1111; storageFull=1 after the 4th digit.
- Continue with D, 1, F while full -> out stays 0x09B3, mask 1111, storageFull 1.
- Hold valid high for 5 cycles with digit=7 from empty -> out=0x0007 and mask 0001 (single entry).
- After entering 1, 2, assert clear for one cycle while valid rises with digit=5 -> out=0x0000, mask 0000, storageFull 0; the next valid pulse with digit=5 gives out=0x0005.
- Assert reset asynchronously after three digits (A, B, C), then release and enter 4 -> all outputs 0 during reset; out=0x0004 and mask 0001 after the new digit.
